// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the registered 1-to-4 demultiplexer.
//   NUM_CH      number of output channels
//   CH_A..CH_D  channel select encodings carried on in_sel
package demux_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef logic [1:0] ch_sel_t;

    localparam ch_sel_t CH_A = 2'd0;
    localparam ch_sel_t CH_B = 2'd1;
    localparam ch_sel_t CH_C = 2'd2;
    localparam ch_sel_t CH_D = 2'd3;

endpackage

// File: rtl/demux_chan_slot.sv
// demux_chan_slot: one-entry output slot with valid flag and wrapping drain counter.
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   load       write load_data into the slot this cycle
//   load_data  word to store
//   out_ready  downstream consumer ready
//   valid      slot holds an undelivered word
//   data       slot contents (kept after drain, qualify with valid)
//   cnt        number of completed drains, wraps at 2^CNT_W
module demux_chan_slot #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    always_comb begin
        drain   = valid_q & out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (drain) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        // A load in the same cycle as a drain refills the slot; the old word was delivered.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: registered 1-to-4 demultiplexer with valid/ready flow control.
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_ready  producer handshake; in_ready reflects the slot chosen by in_sel
//   in_sel, in_data    target channel (0=a..3=d) and word
//   out_valid[3:0]     per-channel slot full
//   out_ready[3:0]     per-channel consumer ready
//   out_a..out_d       per-channel slot data
//   xfer_cnt           packed per-channel drain counters, channel a in the LSBs
module demux_1to4_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [WIDTH-1:0]        out_a,
    output logic [WIDTH-1:0]        out_b,
    output logic [WIDTH-1:0]        out_c,
    output logic [WIDTH-1:0]        out_d,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

    logic [NUM_CH-1:0] load;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
    logic [CNT_W-1:0]  slot_cnt  [NUM_CH];

    // A full slot can still accept when its consumer drains in the same cycle.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            unique case (in_sel)
                CH_A: load[CH_A] = 1'b1;
                CH_B: load[CH_B] = 1'b1;
                CH_C: load[CH_C] = 1'b1;
                CH_D: load[CH_D] = 1'b1;
                default: load = '0;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_chan_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (slot_data[k]),
            .cnt       (slot_cnt[k])
        );
        assign xfer_cnt[k*CNT_W +: CNT_W] = slot_cnt[k];
    end

    assign out_a = slot_data[CH_A];
    assign out_b = slot_data[CH_B];
    assign out_c = slot_data[CH_C];
    assign out_d = slot_data[CH_D];

endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: scoreboard bench. The driver pushes every accepted word into a
// per-channel expected queue; a negedge monitor pops on each output handshake and
// compares data, valid flags and drain counters against the reference model.
module tb_demux_1to4_reg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [WIDTH-1:0]     out_a, out_b, out_c, out_d;
    logic [4*CNT_W-1:0]   xfer_cnt;

    demux_1to4_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pending words per channel, last loaded word, total drains.
    logic [WIDTH-1:0] exp_q [4][$];
    logic [WIDTH-1:0] last_word [4];
    int unsigned      drains [4];
    int               errors = 0;
    int               checks = 0;
    logic             mon_en = 1'b0;

    logic [WIDTH-1:0] out_arr [4];
    assign out_arr[0] = out_a;
    assign out_arr[1] = out_b;
    assign out_arr[2] = out_c;
    assign out_arr[3] = out_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_word[k] = '0;
            drains[k]    = 0;
        end
    endtask

    // Monitor: sample mid-cycle, before the edge at which a handshake takes effect.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]),
                    32'(exp_q[k].size() != 0));
                chk($sformatf("out_data[%0d]", k), 32'(out_arr[k]), 32'(last_word[k]));
                chk($sformatf("xfer_cnt[%0d]", k), 32'(xfer_cnt[k*CNT_W +: CNT_W]),
                    32'(drains[k] % (1 << CNT_W)));
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected drain[%0d]", k), 32'(1), 32'(0));
                    end else begin
                        chk($sformatf("drain order[%0d]", k), 32'(out_arr[k]),
                            32'(exp_q[k].pop_front()));
                        drains[k]++;
                    end
                end
            end
        end
    end

    // One cycle of stimulus; decides acceptance from the model after the monitor's pops.
    task automatic tick(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                        input logic [3:0] r, output logic acc);
        logic model_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        #1;
        // Slot for s is free either because it was empty or because it drains this cycle.
        model_rdy = (exp_q[s].size() == 0);
        chk($sformatf("in_ready sel%0d", s), 32'(in_ready), 32'(model_rdy));
        acc = v && model_rdy;
        if (acc) begin
            exp_q[s].push_back(d);
            last_word[s] = d;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             acc;
        logic             pv;
        logic [1:0]       ps;
        logic [WIDTH-1:0] pd;
        logic [3:0]       pr;
        logic [WIDTH-1:0] seq [4];
        logic [CNT_W-1:0] cnt_before [4];

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Idle after reset: in_ready high for every select.
        for (int s = 0; s < 4; s++) tick(1'b0, 2'(s), '0, 4'b0000, acc);

        // One word to each channel on consecutive cycles, all consumers ready.
        seq[0] = 4'h3; seq[1] = 4'h5; seq[2] = 4'hA; seq[3] = 4'hC;
        for (int s = 0; s < 4; s++) begin
            tick(1'b1, 2'(s), seq[s], 4'b1111, acc);
            chk("route accept", 32'(acc), 32'(1));
        end
        repeat (2) tick(1'b0, 2'd0, '0, 4'b1111, acc);
        for (int k = 0; k < 4; k++)
            chk("route count", 32'(xfer_cnt[k*CNT_W +: CNT_W]), 32'(1));

        // Channel b stalled: second word refused, channel d still flows.
        tick(1'b1, 2'd1, 4'h7, 4'b1101, acc);
        tick(1'b1, 2'd1, 4'h9, 4'b1101, acc);
        chk("stall refuse", 32'(acc), 32'(0));
        chk("stall hold b", 32'(out_b), 32'(4'h7));
        tick(1'b1, 2'd3, 4'h2, 4'b1101, acc);
        chk("bypass accept d", 32'(acc), 32'(1));
        tick(1'b1, 2'd1, 4'h9, 4'b1111, acc);
        chk("unstall accept", 32'(acc), 32'(1));
        repeat (2) tick(1'b0, 2'd0, '0, 4'b1111, acc);

        // Back-to-back words on channel a with consumer always ready.
        cnt_before[0] = xfer_cnt[0 +: CNT_W];
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 2'd0, WIDTH'(i), 4'b1111, acc);
            chk("b2b accept", 32'(acc), 32'(1));
        end
        repeat (2) tick(1'b0, 2'd0, '0, 4'b1111, acc);
        chk("b2b count", 32'(xfer_cnt[0 +: CNT_W]), 32'(CNT_W'(cnt_before[0] + 5)));

        // 256 drains on channel c wrap its counter back; others unchanged.
        for (int k = 0; k < 4; k++) cnt_before[k] = xfer_cnt[k*CNT_W +: CNT_W];
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 2'd2, WIDTH'($urandom), 4'b1111, acc);
        end
        repeat (2) tick(1'b0, 2'd0, '0, 4'b1111, acc);
        for (int k = 0; k < 4; k++)
            chk("wrap count", 32'(xfer_cnt[k*CNT_W +: CNT_W]), 32'(cnt_before[k]));

        // Random traffic; producer holds its word until accepted.
        pv = 1'b0; ps = '0; pd = '0; acc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!pv || acc) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 2'($urandom);
                pd = WIDTH'($urandom);
            end
            pr = 4'($urandom);
            tick(pv, ps, pd, pr, acc);
        end
        repeat (2) tick(1'b0, 2'd0, '0, 4'b1111, acc);

        // Asynchronous reset with slots a and d full.
        tick(1'b1, 2'd0, 4'hB, 4'b0000, acc);
        tick(1'b1, 2'd3, 4'hE, 4'b0000, acc);
        tick(1'b0, 2'd0, '0, 4'b0000, acc);
        @(posedge clk);
        #3;
        chk("pre-reset valid", 32'(out_valid), 32'(4'b1001));
        rstn = 1'b0;
        #1;
        chk("async valid", 32'(out_valid), 32'(0));
        chk("async cnt", xfer_cnt, 32'(0));
        chk("async out_a", 32'(out_a), 32'(0));
        chk("async out_d", 32'(out_d), 32'(0));
        model_clear();
        out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (4) tick(1'b0, 2'd0, '0, 4'b1111, acc);
        chk("post-reset cnt", xfer_cnt, 32'(0));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
